id_exe_fwd_stage: RTL
=====================

Name: id_exe_fwd_stage

Overview:
- ID→EXE pipeline boundary register; consumes the hazard unit's rd1c/rd2c forwarding selects and stall request.
- Muxes forwarded operands, registers them with the ID control word into EXE, and inserts bubbles on stall or flush.
- Drives pc_en/ifid_en back to the front end.
- Keeps a stall performance counter and a stuck-stall watchdog.

Parameters:
- DW, 32, datapath width
- STALL_MAX, 4, consecutive stall cycles after which the watchdog error is raised
- CNT_W, 16, stall performance counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  load-use stall request from hazard unit
- flush  in  1  branch/jump squash of the ID instruction
- rd1c  in  2  operand-1 source: 00 rf, 01 EXE alu, 10 MEM alu, 11 MEM dmem
- rd2c  in  2  operand-2 source, same encoding
- rf_rd1  in  DW  register-file read port 1
- rf_rd2  in  DW  register-file read port 2
- alu_exe  in  DW  ALU result currently in EXE
- alu_mem  in  DW  ALU result in MEM
- dmem_mem  in  DW  dmem read data in MEM
- imm_id  in  DW  extended immediate
- wa_id  in  5  destination register of ID instruction
- wrf_id, wdc_id, aludc_id  in  1 each  ID control bits
- aluop_id  in  4  ALU operation
- opa_exe, opb_exe, imm_exe  out  DW  registered operands
- wa_exe0  out  5  registered destination (feeds hazard unit)
- wrf_exe, wdc_exe, aludc_exe  out  1 each  registered control
- aluop_exe  out  4
- pc_en, ifid_en  out  1  front-end write enables
- stall_cnt  out  CNT_W  saturating count of stall cycles
- wdog_err  out  1  sticky stuck-stall flag

Behaviour:
- Reset (async, immediate): all registered outputs 0. stall_cnt = 0, wdog_err = 0. An all-zero control word is a NOP.
- Operand mux (combinational): fwd1 = rd1c selects rf_rd1 / alu_exe / alu_mem / dmem_mem; fwd2 uses rd2c the same way.
- Normal cycle (stall=0, flush=0), on rising edge:
  - opa_exe ← fwd1, opb_exe ← fwd2
  - imm/wa/control ← ID values
  - Latency 1 cycle.
- Stall cycle (stall=1, flush=0):
  - Bubble loaded: wrf_exe = wdc_exe = aludc_exe = 0, wa_exe0 = 0, aluop_exe = 0.
  - Operand registers keep their previous value (don't-care, held for power).
  - pc_en = ifid_en = 0, combinational from stall, same cycle.
- Flush (flush=1, regardless of stall): bubble loaded; pc_en = ifid_en = 1. Flush has priority over stall.
- pc_en = ifid_en = ~stall | flush.
- Bubble writes wa_exe0 = 0, so the hazard unit's next compare cannot re-match. A second consecutive stall therefore occurs only if the hazard unit re-asserts it.
- stall_cnt increments on every stall cycle with flush=0. It saturates at all-ones and never wraps.
- Watchdog: run counter counts consecutive stall cycles with flush=0, and clears on any non-stall or flush cycle.
  - When the run counter reaches STALL_MAX, wdog_err ← 1.
  - wdog_err is sticky until rst.
  - In a correct pipeline a load-use stall lasts exactly 1 cycle.
- Reset asserted mid-stall: the bubble is discarded and all state is zeroed. After rst deasserts, pc_en follows the stall input.
- rd1c/rd2c are ignored (operands not captured) during stall or flush.

Decomposition:
- Shared package mips_pipe_pkg:
  - Forwarding encodings FWD_RF = 2'b00, FWD_EXE = 2'b01, FWD_MEM_ALU = 2'b10, FWD_MEM_DMEM = 2'b11
  - NOP control-word constant
  - DW default
- One natural sub-module: fwd_mux4, a DW-wide 4:1 operand mux, instantiated twice.
- Counters and watchdog stay inline.

Test Plan:
- Forwarding select: rd1c=01, alu_exe=0x1234, rd2c=11, dmem_mem=0xBEEF, stall=0 → after 1 edge opa_exe=0x1234, opb_exe=0xBEEF, controls copied.
- Load-use stall: wrf_id=1, wa_id=5, stall=1 for one cycle → same cycle pc_en=ifid_en=0. Next edge: wrf_exe=0, wa_exe0=0, stall_cnt=1. Following cycle (stall=0): instruction enters with wa_exe0=5.
- Flush vs stall: stall=1, flush=1 together → bubble loaded, pc_en=ifid_en=1, stall_cnt unchanged.
- Watchdog: STALL_MAX=4, stall held 4 cycles → wdog_err=1 after 4th edge. Stays 1 after stall drops. Clears only on rst.
- Counter saturation: CNT_W=4, 20 stall cycles → stall_cnt=15, no wrap.
- Async reset mid-operation: assert rst between edges during stall → outputs 0 immediately; no pending bubble or capture appears after release.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: forwarding-select encodings and the ID/EXE control word.
package mips_pipe_pkg;

  localparam int DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    FWD_RF       = 2'b00,
    FWD_EXE      = 2'b01,
    FWD_MEM_ALU  = 2'b10,
    FWD_MEM_DMEM = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic       wrf;
    logic       wdc;
    logic       aludc;
    logic [3:0] aluop;
    logic [4:0] wa;
  } ctrl_t;

  // An all-zero control word writes nothing and names register 0, so it is a NOP.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_exe_fwd_stage_if.sv
// ID->EXE boundary bundle: hazard-unit selects, operand sources, ID fields, EXE outputs.
interface id_exe_fwd_stage_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             flush;
  logic [1:0]       rd1c;
  logic [1:0]       rd2c;
  logic [DW-1:0]    rf_rd1;
  logic [DW-1:0]    rf_rd2;
  logic [DW-1:0]    alu_exe;
  logic [DW-1:0]    alu_mem;
  logic [DW-1:0]    dmem_mem;
  logic [DW-1:0]    imm_id;
  logic [4:0]       wa_id;
  logic             wrf_id;
  logic             wdc_id;
  logic             aludc_id;
  logic [3:0]       aluop_id;
  logic [DW-1:0]    opa_exe;
  logic [DW-1:0]    opb_exe;
  logic [DW-1:0]    imm_exe;
  logic [4:0]       wa_exe0;
  logic             wrf_exe;
  logic             wdc_exe;
  logic             aludc_exe;
  logic [3:0]       aluop_exe;
  logic             pc_en;
  logic             ifid_en;
  logic [CNT_W-1:0] stall_cnt;
  logic             wdog_err;

  modport master (
    output stall, flush, rd1c, rd2c, rf_rd1, rf_rd2, alu_exe, alu_mem, dmem_mem,
           imm_id, wa_id, wrf_id, wdc_id, aludc_id, aluop_id,
    input  opa_exe, opb_exe, imm_exe, wa_exe0, wrf_exe, wdc_exe, aludc_exe,
           aluop_exe, pc_en, ifid_en, stall_cnt, wdog_err
  );

  modport slave (
    input  stall, flush, rd1c, rd2c, rf_rd1, rf_rd2, alu_exe, alu_mem, dmem_mem,
           imm_id, wa_id, wrf_id, wdc_id, aludc_id, aluop_id,
    output opa_exe, opb_exe, imm_exe, wa_exe0, wrf_exe, wdc_exe, aludc_exe,
           aluop_exe, pc_en, ifid_en, stall_cnt, wdog_err
  );
endinterface

// File: rtl/id_exe_fwd_stage_fwd_mux4.sv
// DW-wide 4:1 operand-forwarding mux keyed by the hazard unit's select code.
module fwd_mux4
  import mips_pipe_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [1:0]    sel,
  input  logic [DW-1:0] rf,
  input  logic [DW-1:0] exe_alu,
  input  logic [DW-1:0] mem_alu,
  input  logic [DW-1:0] mem_dmem,
  output logic [DW-1:0] dout
);
  always_comb begin
    dout = rf;
    case (sel)
      FWD_RF:       dout = rf;
      FWD_EXE:      dout = exe_alu;
      FWD_MEM_ALU:  dout = mem_alu;
      FWD_MEM_DMEM: dout = mem_dmem;
      default:      dout = rf;
    endcase
  end
endmodule

// File: rtl/id_exe_fwd_stage.sv
// ID->EXE pipeline register with operand forwarding, bubble insertion on stall/flush,
// a saturating stall counter and a sticky stuck-stall watchdog.
module id_exe_fwd_stage
  import mips_pipe_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int STALL_MAX = 4,
  parameter int CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  id_exe_fwd_stage_if.slave bus
);
  localparam int RUN_W = $clog2(STALL_MAX + 1);

  logic [DW-1:0]    fwd1;
  logic [DW-1:0]    fwd2;
  logic [DW-1:0]    opa_reg;
  logic [DW-1:0]    opb_reg;
  logic [DW-1:0]    imm_reg;
  ctrl_t            ctrl_reg;
  ctrl_t            ctrl_id;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [RUN_W-1:0] run_reg;
  logic [RUN_W-1:0] run_next;
  logic             wdog_reg;
  logic             bubble;
  logic             stall_only;

  fwd_mux4 #(.DW(DW)) u_mux_a (
    .sel(bus.rd1c), .rf(bus.rf_rd1), .exe_alu(bus.alu_exe),
    .mem_alu(bus.alu_mem), .mem_dmem(bus.dmem_mem), .dout(fwd1)
  );

  fwd_mux4 #(.DW(DW)) u_mux_b (
    .sel(bus.rd2c), .rf(bus.rf_rd2), .exe_alu(bus.alu_exe),
    .mem_alu(bus.alu_mem), .mem_dmem(bus.dmem_mem), .dout(fwd2)
  );

  assign bubble     = bus.stall | bus.flush;
  assign stall_only = bus.stall & ~bus.flush;

  always_comb begin
    ctrl_id       = CTRL_NOP;
    ctrl_id.wrf   = bus.wrf_id;
    ctrl_id.wdc   = bus.wdc_id;
    ctrl_id.aludc = bus.aludc_id;
    ctrl_id.aluop = bus.aluop_id;
    ctrl_id.wa    = bus.wa_id;
  end

  // Run length saturates at STALL_MAX so the counter never wraps back below the trip point.
  always_comb begin
    run_next = '0;
    if (stall_only) begin
      run_next = (run_reg == RUN_W'(STALL_MAX)) ? run_reg : run_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_reg       <= '0;
      opb_reg       <= '0;
      imm_reg       <= '0;
      ctrl_reg      <= CTRL_NOP;
      stall_cnt_reg <= '0;
      run_reg       <= '0;
      wdog_reg      <= 1'b0;
    end else begin
      // Operands are only captured for a real instruction; a bubble leaves them parked.
      if (bubble) begin
        ctrl_reg <= CTRL_NOP;
      end else begin
        opa_reg  <= fwd1;
        opb_reg  <= fwd2;
        imm_reg  <= bus.imm_id;
        ctrl_reg <= ctrl_id;
      end
      if (stall_only && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      run_reg <= run_next;
      if (run_next == RUN_W'(STALL_MAX)) begin
        wdog_reg <= 1'b1;
      end
    end
  end

  assign bus.opa_exe   = opa_reg;
  assign bus.opb_exe   = opb_reg;
  assign bus.imm_exe   = imm_reg;
  assign bus.wa_exe0   = ctrl_reg.wa;
  assign bus.wrf_exe   = ctrl_reg.wrf;
  assign bus.wdc_exe   = ctrl_reg.wdc;
  assign bus.aludc_exe = ctrl_reg.aludc;
  assign bus.aluop_exe = ctrl_reg.aluop;
  assign bus.pc_en     = ~bus.stall | bus.flush;
  assign bus.ifid_en   = ~bus.stall | bus.flush;
  assign bus.stall_cnt = stall_cnt_reg;
  assign bus.wdog_err  = wdog_reg;
endmodule
